// File: rtl/fetch_pc_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_if -- signal bundle between the fetch stage and its environment
//
// Groups everything fetch_pc exchanges with the decode stage, the hazard unit,
// the external pc+4 adder and instruction memory. clk and reset are not part
// of the bundle; they are plain ports on the module.
//
//   Environment -> fetch (slave inputs):
//     stall      hazard stall, freezes pc and the IF/ID register
//     exc_req    exception entry request from later stages
//     npc_sel    next-pc select from D (00 seq, 01 branch, 10 j/jal, 11 jr/jalr)
//     cmp_taken  branch comparator result in D
//     imm16      branch offset field of ir_d
//     imm26      jump index field of ir_d
//     rs_data    forwarded register target for jr/jalr
//     pc_4       pc+4 from the external adder
//     instr_in   instruction word read from instruction memory at pc
//   Fetch -> environment (slave outputs):
//     pc         current fetch address (registered)
//     ir_d       IF/ID instruction register
//     pc_d       IF/ID copy of the fetch pc
//     pc4_d      IF/ID copy of pc_4
//     adel_d     IF/ID fetch-fault flag
//
// There is no valid/ready handshake on this bundle: every rising clk edge is a
// transfer. stall is the only back-pressure and it holds the whole stage.
// -----------------------------------------------------------------------------
interface fetch_pc_if;
  logic        stall;
  logic        exc_req;
  logic [1:0]  npc_sel;
  logic        cmp_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic [31:0] pc_4;
  logic [31:0] instr_in;

  logic [31:0] pc;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        adel_d;

  // The fetch stage itself.
  modport slave (
    input  stall, exc_req, npc_sel, cmp_taken, imm16, imm26, rs_data,
           pc_4, instr_in,
    output pc, ir_d, pc_d, pc4_d, adel_d
  );

  // Whatever drives the fetch stage (pipeline control, memory model, bench).
  modport master (
    output stall, exc_req, npc_sel, cmp_taken, imm16, imm26, rs_data,
           pc_4, instr_in,
    input  pc, ir_d, pc_d, pc4_d, adel_d
  );
endinterface

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc -- program counter and IF/ID pipeline register
//
// Holds the fetch address and the IF/ID register of a MIPS-style pipeline
// with a branch delay slot. The next pc is chosen from the decode stage's
// npc_sel using the IF/ID copy of pc+4 (pc4_d) as the base for branches and
// jumps, so a redirect decided in D lands one cycle later while the delay
// slot instruction, already being fetched, enters D normally.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous active-high reset
//   bus    fetch_pc_if.slave (see the interface file for the signal list)
//
// Edge priority: reset > exc_req > stall > normal update.
// -----------------------------------------------------------------------------
module fetch_pc (
  input  logic       clk,
  input  logic       reset,
  fetch_pc_if.slave  bus
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  // Inclusive bounds of the legal instruction region.
  localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JREG   = 2'b11;

  // What the stage does at the coming edge when reset is low. Reset itself is
  // applied in the register process, so it is not one of these.
  typedef enum logic [1:0] {
    UPD_NORMAL = 2'b00,
    UPD_HOLD   = 2'b01,
    UPD_EXC    = 2'b10
  } upd_e;

  // State registers.
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ir_d_q,     ir_d_d;
  logic [31:0] pc_d_q,     pc_d_d;
  logic [31:0] pc4_d_q,    pc4_d_d;
  logic        adel_d_q,   adel_d_d;

  // Combinational helpers.
  upd_e        upd_kind;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] npc;
  logic        fetch_fault;

  // ---------------------------------------------------------------------------
  // Target generation. Branch and jump targets are relative to the delay-slot
  // address held in pc4_d, not to the current fetch pc.
  // ---------------------------------------------------------------------------
  always_comb begin
    br_offset   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    br_target   = pc4_d_q + br_offset;   // wraps modulo 2^32
    jump_target = {pc4_d_q[31:28], bus.imm26, 2'b00};
  end

  always_comb begin
    npc = bus.pc_4;
    unique case (bus.npc_sel)
      NPC_SEQ:    npc = bus.pc_4;
      NPC_BRANCH: npc = bus.cmp_taken ? br_target : bus.pc_4;
      NPC_JUMP:   npc = jump_target;
      NPC_JREG:   npc = bus.rs_data;
      default:    npc = bus.pc_4;
    endcase
  end

  // A misaligned or out-of-region fetch address. The pc keeps advancing from
  // a faulting address; the fault is only reported through adel_d.
  always_comb begin
    fetch_fault = (fetch_pc_q[1:0] != 2'b00) ||
                  (fetch_pc_q < TEXT_LO)     ||
                  (fetch_pc_q > TEXT_HI);
  end

  // exc_req wins over stall so exception entry is never blocked by a hazard.
  always_comb begin
    if (bus.exc_req) begin
      upd_kind = UPD_EXC;
    end else if (bus.stall) begin
      upd_kind = UPD_HOLD;
    end else begin
      upd_kind = UPD_NORMAL;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Defaults hold every register; each update kind then
  // overrides what it changes.
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    ir_d_d     = ir_d_q;
    pc_d_d     = pc_d_q;
    pc4_d_d    = pc4_d_q;
    adel_d_d   = adel_d_q;

    unique case (upd_kind)
      UPD_EXC: begin
        // Vector to the handler and push a bubble (all-zero nop) into D.
        fetch_pc_d = EXC_PC;
        ir_d_d     = 32'h0;
        pc_d_d     = 32'h0;
        pc4_d_d    = 32'h0;
        adel_d_d   = 1'b0;
      end
      UPD_HOLD: begin
        // Everything holds; the redirect request in D is ignored now and is
        // presented again by the same D instruction once the stall drops.
      end
      UPD_NORMAL: begin
        // A redirect never flushes IF/ID: the delay slot is captured here.
        fetch_pc_d = npc;
        ir_d_d     = fetch_fault ? 32'h0 : bus.instr_in;
        pc_d_d     = fetch_pc_q;
        pc4_d_d    = bus.pc_4;
        adel_d_d   = fetch_fault;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers with synchronous reset; reset overrides exc_req and stall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      ir_d_q     <= 32'h0;
      pc_d_q     <= 32'h0;
      pc4_d_q    <= 32'h0;
      adel_d_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ir_d_q     <= ir_d_d;
      pc_d_q     <= pc_d_d;
      pc4_d_q    <= pc4_d_d;
      adel_d_q   <= adel_d_d;
    end
  end

  // pc is taken straight from the register, so it has no combinational path
  // from any input.
  assign bus.pc     = fetch_pc_q;
  assign bus.ir_d   = ir_d_q;
  assign bus.pc_d   = pc_d_q;
  assign bus.pc4_d  = pc4_d_q;
  assign bus.adel_d = adel_d_q;

endmodule

// File: tb/tb_fetch_pc.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc -- self-checking bench for fetch_pc
//
// The driver issues one set of inputs per cycle and pushes the state the
// stage must hold after that edge into exp_q. A separate monitor pops one
// entry after every edge and compares it with the DUT. Directed sequences
// also check key values against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_fetch_pc;

  localparam int W = 129;  // {pc, ir_d, pc_d, pc4_d, adel_d}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_if bus ();

  fetch_pc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // External adder and instruction memory follow the DUT's pc.
  assign bus.pc_4     = bus.pc + 32'd4;
  assign bus.instr_in = imem(bus.pc);

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_ir   = 32'h0;
  logic [31:0] m_pcd  = 32'h0;
  logic [31:0] m_pc4d = 32'h0;
  logic        m_adel = 1'b0;

  task automatic model_edge(input logic r, input logic e, input logic s,
                            input logic [1:0] sel, input logic ct,
                            input logic [15:0] i16, input logic [25:0] i26,
                            input logic [31:0] rs);
    logic [31:0] seq, tgt, off;
    logic        bad;
    seq = m_pc + 32'd4;
    off = {{16{i16[15]}}, i16} * 32'd4;
    case (sel)
      2'd0: tgt = seq;
      2'd1: tgt = ct ? (m_pc4d + off) : seq;
      2'd2: tgt = (m_pc4d & 32'hF000_0000) | ({6'd0, i26} << 2);
      default: tgt = rs;
    endcase
    bad = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
    if (r) begin
      m_pc = 32'h3000; m_ir = 0; m_pcd = 0; m_pc4d = 0; m_adel = 0;
    end else if (e) begin
      m_pc = 32'h4180; m_ir = 0; m_pcd = 0; m_pc4d = 0; m_adel = 0;
    end else if (!s) begin
      m_ir   = bad ? 32'h0 : imem(m_pc);
      m_adel = bad;
      m_pcd  = m_pc;
      m_pc4d = seq;
      m_pc   = tgt;
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the falling edge; returns 2 units after
  // the next rising edge so directed checks see the updated state.
  task automatic step(input logic r, input logic e, input logic s,
                      input logic [1:0] sel, input logic ct,
                      input logic [15:0] i16, input logic [25:0] i26,
                      input logic [31:0] rs);
    @(negedge clk); #1;
    reset         = r;
    bus.exc_req   = e;
    bus.stall     = s;
    bus.npc_sel   = sel;
    bus.cmp_taken = ct;
    bus.imm16     = i16;
    bus.imm26     = i26;
    bus.rs_data   = rs;
    model_edge(r, e, s, sel, ct, i16, i26, rs);
    exp_q.push_back({m_pc, m_ir, m_pcd, m_pc4d, m_adel});
    @(posedge clk); #2;
  endtask

  task automatic idle();
    step(0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.pc, bus.ir_d, bus.pc_d, bus.pc4_d, bus.adel_d};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL scoreboard cyc %0d: pc %h/%h ir_d %h/%h pc_d %h/%h pc4_d %h/%h adel_d %b/%b (got/expected)",
                   cyc, a[128:97], e[128:97], a[96:65], e[96:65],
                   a[64:33], e[64:33], a[32:1], e[32:1], a[0], e[0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        r, e, s, ct;
    logic [1:0]  sel;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;

    bus.exc_req = 0; bus.stall = 0; bus.npc_sel = 0; bus.cmp_taken = 0;
    bus.imm16 = 0; bus.imm26 = 0; bus.rs_data = 0;

    // Reset and sequential fetch.
    step(1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    chk("reset_pc", bus.pc, 32'h3000);
    chk("reset_ir_d", bus.ir_d, 32'h0);
    chk("reset_pc_d", bus.pc_d, 32'h0);
    chk("reset_pc4_d", bus.pc4_d, 32'h0);
    chk("reset_adel_d", {31'd0, bus.adel_d}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk("seq_pc", bus.pc, 32'h3000 + 32'(4 * k));
      chk("seq_pc_d", bus.pc_d, 32'h3000 + 32'(4 * (k - 1)));
      chk("seq_pc4_d", bus.pc4_d, 32'h3000 + 32'(4 * k));
      chk("seq_ir_d", bus.ir_d, imem(32'h3000 + 32'(4 * (k - 1))));
    end

    // Jump with pc4_d = 0x3010, then jr to a misaligned address.
    step(0, 0, 0, 2'd2, 0, 16'h0, 26'h0000C10, 32'h0);
    chk("jump_pc", bus.pc, 32'h3040);
    chk("jump_delay_slot_ir_d", bus.ir_d, imem(32'h3010));
    step(0, 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3001);
    chk("jr_pc", bus.pc, 32'h3001);
    idle();
    chk("jr_fault_adel_d", {31'd0, bus.adel_d}, 32'h1);
    chk("jr_fault_ir_d", bus.ir_d, 32'h0);
    chk("fault_pc_advances", bus.pc, 32'h3005);

    // Region boundaries: 0x6FFC is legal, 0x7000 and 0x2FFC are not.
    step(0, 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h6FFC);
    idle();
    chk("top_edge_adel_d", {31'd0, bus.adel_d}, 32'h0);
    chk("top_edge_ir_d", bus.ir_d, imem(32'h6FFC));
    idle();
    chk("above_top_adel_d", {31'd0, bus.adel_d}, 32'h1);
    step(0, 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h2FFC);
    idle();
    chk("below_base_adel_d", {31'd0, bus.adel_d}, 32'h1);

    // Branch taken with pc4_d = 0x3008 and offset -2 words.
    step(1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    idle();
    idle();
    chk("pre_branch_pc4_d", bus.pc4_d, 32'h3008);
    step(0, 0, 0, 2'd1, 1, 16'hFFFE, 26'h0, 32'h0);
    chk("branch_pc", bus.pc, 32'h3000);
    chk("branch_delay_slot_ir_d", bus.ir_d, imem(32'h3008));
    chk("branch_pc_d", bus.pc_d, 32'h3008);

    // Stall for two cycles with a jump pending, then release.
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1, 2'd2, 0, 16'h0, 26'h0000C20, 32'h0);
      chk("stall_pc", bus.pc, 32'h3000);
      chk("stall_ir_d", bus.ir_d, imem(32'h3008));
      chk("stall_pc_d", bus.pc_d, 32'h3008);
      chk("stall_pc4_d", bus.pc4_d, 32'h300C);
    end
    step(0, 0, 0, 2'd2, 0, 16'h0, 26'h0000C20, 32'h0);
    chk("stall_release_pc", bus.pc, 32'h3080);
    chk("stall_release_ir_d", bus.ir_d, imem(32'h3000));

    // Simultaneous events.
    step(0, 1, 1, 2'd3, 0, 16'h0, 26'h0, 32'h1234);
    chk("exc_stall_pc", bus.pc, 32'h4180);
    chk("exc_stall_ir_d", bus.ir_d, 32'h0);
    chk("exc_stall_pc4_d", bus.pc4_d, 32'h0);
    step(1, 1, 1, 2'd3, 0, 16'h0, 26'h0, 32'h1234);
    chk("reset_exc_pc", bus.pc, 32'h3000);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      e   = ($urandom_range(0, 31) == 0);
      s   = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      ct  = 1'($urandom_range(0, 1));
      i16 = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 31) - 16);
      i26 = 26'($urandom_range(32'h3000, 32'h6FFC) >> 2);
      if ($urandom_range(0, 7) == 0) i26 = 26'($urandom);
      rs  = ($urandom_range(0, 1) == 0) ? 32'h3000 + 32'(4 * $urandom_range(0, 4095))
                                        : $urandom;
      step(r, e, s, sel, ct, i16, i26, rs);
    end

    // Let the monitor consume the last entry, then confirm nothing is left.
    @(posedge clk); #3;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
